// File: rtl/csa_add_scheduler.sv
// csa_add_scheduler: round-robin, nibble-serial WIDTH-bit adder sharing one 4-bit carry-skip slice; CSA_SCHED_OVF_EN adds resp_ovf
module CarrySkipAdder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p;
  logic [4:0] c;
  always_comb begin
    p = a ^ b;
    c = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) c[i+1] = (a[i] & b[i]) | (p[i] & c[i]);
    sum = p ^ c[3:0];
    cout = &p ? cin : c[4];
  end
endmodule

module csa_add_scheduler #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req0_cin,
  input  logic             req1_cin,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_sum,
  output logic             resp_cout,
  output logic             resp_id,
  output logic             busy
`ifdef CSA_SCHED_OVF_EN
  ,
  output logic             resp_ovf
`endif
);
  localparam int N = WIDTH / 4;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic prio, grant, acc, id, c, last, nc;
  logic [WIDTH-1:0] a, b, work, work_nx;
  logic [IW-1:0] idx;
  logic [3:0] na, nb, ns;
  CarrySkipAdder u_slice (.a(na), .b(nb), .cin(c), .sum(ns), .cout(nc));
  always_comb begin
    grant = (req0_valid & req1_valid) ? prio : req1_valid;
    req0_ready = (state == IDLE) & !grant & !rst;
    req1_ready = (state == IDLE) & grant & !rst;
    acc = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    last = idx == IW'(N - 1);
    na = a[idx*4 +: 4];
    nb = b[idx*4 +: 4];
    work_nx = work;
    work_nx[idx*4 +: 4] = ns;
    state_nx = state == IDLE ? (acc ? CALC : IDLE) :
               state == CALC ? (last ? DONE : CALC) :
               (resp_ready ? IDLE : DONE);
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio <= 1'b0;
      id <= 1'b0;
      c <= 1'b0;
      idx <= '0;
      a <= '0;
      b <= '0;
      work <= '0;
      resp_valid <= 1'b0;
      resp_sum <= '0;
      resp_cout <= 1'b0;
      resp_id <= 1'b0;
`ifdef CSA_SCHED_OVF_EN
      resp_ovf <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      resp_valid <= state_nx == DONE;
      if (acc) begin
        a <= grant ? req1_a : req0_a;
        b <= grant ? req1_b : req0_b;
        c <= grant ? req1_cin : req0_cin;
        idx <= '0;
        id <= grant;
        prio <= !grant;
      end else if (state == CALC) begin
        work <= work_nx;
        c <= nc;
        idx <= last ? idx : idx + 1'b1;
        if (last) begin
          resp_sum <= work_nx;
          resp_cout <= nc;
          resp_id <= id;
`ifdef CSA_SCHED_OVF_EN
          resp_ovf <= a[WIDTH-1] ^ b[WIDTH-1] ^ ns[3] ^ nc;
`endif
        end
      end
    end
  end
endmodule

// File: doc/csa_add_scheduler.md
# csa_add_scheduler

Multi-cycle wide-operand adder controller that time-shares a single instance of the team's 4-bit carry-skip adder slice (`CarrySkipAdder`) between two requesters. It arbitrates round-robin and accepts one addition per transaction. It then sequences the operands through the slice one nibble per cycle, least-significant nibble first, with the carry chained through a register. The block sits between two client ports and one response port, for area-constrained datapaths that need WIDTH-bit adds without a full-width adder.

## Interface
Parameters:
- `WIDTH`, default 16: operand width; must be a multiple of 4 and at least 4. `N = WIDTH/4` nibble steps.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester has an operation pending.
- `req0_ready`, `req1_ready`  out  1  requester's operation is accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH  operands.
- `req0_cin`, `req1_cin`  in  1  carry-in.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_sum`  out  WIDTH  sum.
- `resp_cout`  out  1  carry-out of bit WIDTH-1.
- `resp_id`  out  1  index of the requester that issued the result.
- `busy`  out  1  high in CALC or DONE.
- `resp_ovf`  out  1  signed overflow. Present only with `CSA_SCHED_OVF_EN`.

## Operation
- State machine with three states: IDLE, CALC and DONE. Reset state is IDLE.
- **IDLE: arbitration.**
  - Grant goes to the only valid requester. If both are valid, grant goes to the requester named by the priority pointer `prio`. `prio` resets to 0.
  - `reqX_ready = (state==IDLE) & grant==X & !rst`. Ready is combinational from the state and both valids.
  - A handshake occurs when `valid & ready`. At that edge the block latches a, b and cin, sets nibble index `idx=0` and carry register `c=cin`, records `id`, moves to CALC, and sets `prio` to the requester that did not win.
- **CALC: nibble sequencing.**
  - Each cycle, feed slice nibble `idx` of a and b, plus `c`.
  - At the edge, write the slice sum into work-register nibble `idx`, set `c` to the slice cout, and increment `idx`.
  - When `idx==N-1`:
    - Copy the work register, including the final nibble, to `resp_sum`.
    - Set `resp_cout` to the slice cout.
    - Set `resp_id` to `id`.
    - Set `resp_valid` to 1 and move to DONE.
- **DONE: response handshake.**
  - `resp_*` are held stable.
  - When `resp_valid & resp_ready`, clear `resp_valid` at the edge and return to IDLE.
  - No request is accepted in CALC or DONE; both readys are 0.
- `resp_sum`, `resp_cout`, `resp_id` and `resp_ovf` keep their last values after the handshake until the next completion.
- Arithmetic is modulo 2^WIDTH. `resp_cout` is the true carry-out. `idx` is `$clog2(N)` bits wide (minimum 1) and never wraps past N-1.
- **Reset.** `rst` asserted at any time, including mid-CALC or in DONE:
  - The in-flight operation is discarded with no response.
  - Every output goes to 0 immediately: readys 0, `resp_valid` 0, `resp_sum` 0, `resp_cout` 0, `resp_id` 0, `busy` 0, `resp_ovf` 0.
  - `prio` returns to 0.
- Requester-side input changes while not ready are ignored. Operands are sampled only at the handshake edge.

## Timing
- Acceptance edge is t0. `resp_valid` rises at edge t0+N (N=4 for WIDTH=16).
- With `resp_ready` held high, the response handshake completes at t0+N+1. The earliest next acceptance edge is t0+N+2.
- Peak throughput is one operation per N+2 cycles.
- `busy` is registered via the state: high from t0 through the response-handshake edge.
- The critical path is one 4-bit slice plus the carry register mux. There is no combinational path from `resp_ready` to any output.

## Configuration
- `CSA_SCHED_OVF_EN` defined:
  - Adds the `resp_ovf` port.
  - At completion, `resp_ovf` is set to `a[W-1] ^ b[W-1] ^ sum[W-1] ^ cout`, i.e. carry-into-MSB XOR carry-out.
  - It is updated and held exactly like `resp_sum`.
- `CSA_SCHED_OVF_EN` undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- **Single op.** WIDTH=16; req0 a=0x1234, b=0x0FFF, cin=0; `resp_ready`=1 → `resp_valid` at t0+4; sum=0x2233, cout=0, id=0; `busy` low at t0+6.
- **Full propagate.** req1 a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=1, id=1. Carry chains through all 4 nibbles.
- **Contention.** Both valid right after reset → req0 is served first (prio=0). req1 is accepted at t0+6, with id=1 on its response. Then, with both valid again, req0 wins.
- **Backpressure.** `resp_ready`=0 for 3 cycles after `resp_valid` → `resp_valid`, sum and id are held stable, both readys stay 0. Completion occurs on the cycle `resp_ready` rises.
- **Reset mid-op.** Pulse `rst` at t0+2 → all outputs 0 immediately and no `resp_valid`. A new op after reset completes correctly: 0x00FF+0x0001 → 0x0100.
- **Overflow (with `CSA_SCHED_OVF_EN`).**
  - 0x7FFF+0x0001 → sum=0x8000, ovf=1, cout=0.
  - 0xFFFF+0x0001 → ovf=0, cout=1.
